// File: rtl/isa_pkg.sv
// Shared ISA definitions: the opcode set understood by decode-stage control,
// the instruction-memory loader state encoding, and loader error codes.
package isa_pkg;

  // Opcode field is instr[31:27].
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  typedef enum logic [2:0] {
    LD_HDR_HI = 3'd0,
    LD_HDR_LO = 3'd1,
    LD_DATA   = 3'd2,
    LD_CHECK  = 3'd3,
    LD_DONE   = 3'd4,
    LD_ERROR  = 3'd5
  } ld_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_COUNT    = 2'd1;
  localparam logic [1:0] ERR_OPCODE   = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/opcode_legal.sv
// Combinational opcode legality check.
//   opcode_i : instr[31:27]
//   legal_o  : 1 when the opcode is one the decode stage understands
module opcode_legal
  import isa_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (opcode_i)
      OP_ALU, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI,
      OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX: legal_o = 1'b1;
      default:                               legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streaming instruction-memory loader. Consumes a byte stream of
// {count[15:8], count[7:0], N big-endian 32-bit words, xor checksum},
// writes the words to IMEM from address 0 and keeps the core in reset
// until the image has been checked.
//   clock/reset        : clock, async active-high reset
//   in_data/valid/ready: byte stream (transfer = in_valid & in_ready)
//   restart            : pulse, re-arms the loader from DONE or ERROR
//   imem_addr/data/we  : IMEM write port, one-cycle we pulse per word
//   cpu_hold           : core reset hold
//   done/error/err_code: load status
module imem_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       asm_q, asm_d;
  logic [7:0]        acc_q, acc_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic        xfer;
  logic [31:0] word;
  logic [15:0] hdr_cnt;
  logic        op_ok;
  logic        last_word;

  assign xfer      = in_valid & ready_q;
  // Word as it stands once the current byte is shifted in; only meaningful
  // on the 4th byte, where it is both checked and written.
  assign word      = {asm_q[23:0], in_data};
  assign hdr_cnt   = {count_q[15:8], in_data};
  assign last_word = ({{(32-ADDR_W){1'b0}}, widx_q} == ({16'd0, count_q} - 32'd1));

  opcode_legal u_opcode_legal (
    .opcode_i (word[31:27]),
    .legal_o  (op_ok)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LD_HDR_HI;
      count_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    code_d  = code_q;

    case (state_q)
      LD_HDR_HI: if (xfer) begin
        count_d[15:8] = in_data;
        state_d       = LD_HDR_LO;
      end
      LD_HDR_LO: if (xfer) begin
        count_d = hdr_cnt;
        if ({16'd0, hdr_cnt} > MAX_WORDS) begin
          state_d = LD_ERROR;
          code_d  = ERR_COUNT;
        end else if (hdr_cnt == 16'd0) begin
          state_d = LD_CHECK;
        end else begin
          state_d = LD_DATA;
        end
      end
      LD_DATA: if (xfer) begin
        asm_d  = word;
        acc_d  = acc_q ^ in_data;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          if (op_ok) begin
            we_d   = 1'b1;
            addr_d = widx_q;
            data_d = word;
            widx_d = widx_q + 1'b1;  // may wrap after the final word; unused then
            if (last_word) state_d = LD_CHECK;
          end else begin
            state_d = LD_ERROR;
            code_d  = ERR_OPCODE;
          end
        end
      end
      LD_CHECK: if (xfer) begin
        if (in_data == acc_q) begin
          state_d = LD_DONE;
        end else begin
          state_d = LD_ERROR;
          code_d  = ERR_CHECKSUM;
        end
      end
      LD_DONE, LD_ERROR: if (restart) begin
        state_d = LD_HDR_HI;
        count_d = '0;
        widx_d  = '0;
        bidx_d  = '0;
        acc_d   = '0;
        code_d  = ERR_NONE;
      end
      default: state_d = LD_HDR_HI;
    endcase

    // Status outputs are registered copies of the next state.
    ready_d = !(state_d inside {LD_DONE, LD_ERROR});
    hold_d  = (state_d != LD_DONE);
    done_d  = (state_d == LD_DONE);
    err_d   = (state_d == LD_ERROR);
  end

  assign in_ready  = ready_q;
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus randomized
// images, compared against a stream-parsing reference model.
module tb_imem_loader;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          restart;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_we;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .restart   (restart),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .imem_we   (imem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]    stream[$];
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  logic [AW-1:0] exp_a[$];
  logic [31:0]   exp_d[$];
  logic          exp_done, exp_error;
  logic [1:0]    exp_code;
  logic          hold_at_last;
  logic [31:0]   save_d[$];
  logic [4:0]    legal_ops[11] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                                   5'h06, 5'h07, 5'h08, 5'h15, 5'h16};

  // Collect every write pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      got_a.push_back(imem_addr);
      got_d.push_back(imem_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: walk the byte stream as the format defines it.
  task automatic model();
    int cnt, pos;
    logic [31:0] w;
    logic [7:0]  x;
    exp_a.delete(); exp_d.delete();
    exp_done = 0; exp_error = 0; exp_code = 0; x = 0;
    cnt = {16'd0, stream[0], stream[1]};
    if (cnt > (1 << AW)) begin exp_error = 1; exp_code = 1; return; end
    pos = 2;
    for (int i = 0; i < cnt; i++) begin
      w = {stream[pos], stream[pos+1], stream[pos+2], stream[pos+3]};
      for (int k = 0; k < 4; k++) x ^= stream[pos+k];
      pos += 4;
      if (!is_legal(w[31:27])) begin exp_error = 1; exp_code = 2; return; end
      exp_a.push_back(AW'(i));
      exp_d.push_back(w);
    end
    if (stream[pos] == x) exp_done = 1;
    else begin exp_error = 1; exp_code = 3; end
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [31:0] w;
    logic [7:0]  x;
    stream.delete(); x = 0;
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = {legal_ops[$urandom_range(10)], 27'($urandom)};
      for (int k = 3; k >= 0; k--) begin
        stream.push_back(w[k*8 +: 8]);
        x ^= w[k*8 +: 8];
      end
    end
    stream.push_back(corrupt ? ~x : x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(negedge clock); in_valid = 1'b0; end
    @(negedge clock);
    in_data = b; in_valid = 1'b1;
    hold_at_last = cpu_hold;
    @(posedge clock);
  endtask

  task automatic send_all(input int maxgap);
    foreach (stream[i]) send_byte(stream[i], maxgap > 0 ? $urandom_range(maxgap) : 0);
  endtask

  task automatic check_result();
    @(negedge clock); in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("n_writes", got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk("wr_addr", 32'(got_a[i]), 32'(exp_a[i]));
      chk("wr_data", got_d[i], exp_d[i]);
    end
    chk("done", done, exp_done);
    chk("error", error, exp_error);
    chk("err_code", err_code, exp_code);
    chk("cpu_hold", cpu_hold, !exp_done);
    chk("in_ready", in_ready, !(exp_done || exp_error));
  endtask

  task automatic do_restart();
    @(negedge clock); restart = 1'b1;
    @(negedge clock); restart = 1'b0;
    chk("rs_in_ready", in_ready, 1'b1);
    chk("rs_error", error, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_hold", cpu_hold, 1'b1);
    chk("rs_code", err_code, 2'd0);
    got_a.delete(); got_d.delete();
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; restart = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_code", err_code, 2'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Two-word image with good checksum; cpu_hold drops one cycle after it.
    stream = '{8'h00, 8'h02, 8'h28, 8'h20, 8'h00, 8'h05, 8'h38, 8'h20, 8'h00, 8'h00, 8'h15};
    model();
    send_all(0);
    chk("hold_before_cks", hold_at_last, 1'b1);
    #1;
    chk("hold_after_cks", cpu_hold, 1'b0);
    check_result();
    if (got_d.size() == 2) begin
      chk("w0_literal", got_d[0], 32'h28200005);
      chk("w1_literal", got_d[1], 32'h38200000);
    end else chk("w_literal_count", got_d.size(), 2);
    do_restart();

    // Same image, bad checksum.
    stream[10] = 8'h15 ^ 8'hFF;
    model();
    send_all(0);
    check_result();
    do_restart();

    // Illegal opcode 01001.
    stream = '{8'h00, 8'h01, 8'h48, 8'h00, 8'h00, 8'h00};
    model();
    send_all(0);
    check_result();
    do_restart();

    // Count one above capacity.
    stream = '{8'h00, 8'h11};
    model();
    send_all(0);
    check_result();
    do_restart();

    // Empty image.
    stream = '{8'h00, 8'h00, 8'h00};
    model();
    send_all(0);
    check_result();
    do_restart();

    // Full-capacity random image, gap-free then gapped.
    build_random(1 << AW, 0);
    model();
    send_all(0);
    check_result();
    save_d = got_d;
    do_restart();
    send_all(5);
    check_result();
    chk("gap_same_n", got_d.size(), save_d.size());
    for (int i = 0; i < save_d.size() && i < got_d.size(); i++)
      chk("gap_same_data", got_d[i], save_d[i]);
    do_restart();

    // A few random images, some corrupted.
    for (int t = 0; t < 4; t++) begin
      build_random($urandom_range(1, 1 << AW), t[0]);
      model();
      send_all(3);
      check_result();
      do_restart();
    end

    // Reset after 2nd byte of word 1, then full reload.
    build_random(2, 0);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    @(negedge clock); in_valid = 1'b0;
    chk("pre_rst_writes", got_a.size(), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_hold", cpu_hold, 1'b1);
    @(negedge clock); reset = 1'b0;
    got_a.delete(); got_d.delete();
    build_random(2, 0);
    model();
    send_all(0);
    check_result();
    do_restart();

    // Reset landing on a live write pulse clears it asynchronously.
    build_random(1, 0);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    #1;
    chk("pulse_live", imem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("pulse_async_clr", imem_we, 1'b0);
    @(negedge clock); reset = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
